// File: rtl/block_fetch_pkg.sv
// Shared types and sizing helpers for the block fetch responder.
package block_fetch_pkg;

  // Default configuration of the responder.
  localparam int DWIDTH_DEF           = 32'd5;
  localparam int BLOCK_WIDTH_BITS_DEF = 32'd5;
  localparam int ADDR_IN_WIDTH_DEF    = 32'd20;

  // Responder control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Width of a block address, given the word-address width and the log2 block size.
  function automatic int blk_addr_width(input int addr_w, input int blk_bits);
    return addr_w - blk_bits;
  endfunction

  // Number of words in one block.
  function automatic int words_per_block(input int blk_bits);
    return 32'd1 << blk_bits;
  endfunction

endpackage

// File: rtl/block_fetch_responder.sv
// Memory-side block refill responder: fetches 2**BLOCK_WIDTH_BITS words over an
// arbitrated single-cycle memory port and returns the whole block at once.
// Optional build macro: BLOCK_RESP_REUSE_EN - answers a repeat of the most
// recently fetched block address straight away without memory traffic.
module block_fetch_responder
  import block_fetch_pkg::*;
#(
  parameter int DWIDTH           = DWIDTH_DEF,
  parameter int BLOCK_WIDTH_BITS = BLOCK_WIDTH_BITS_DEF,
  parameter int ADDR_IN_WIDTH    = ADDR_IN_WIDTH_DEF
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  req_valid,
  input  logic [blk_addr_width(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS)-1:0] req_addr,
  output logic                                                  req_ready,
  output logic [DWIDTH*words_per_block(BLOCK_WIDTH_BITS)-1:0]   block_data,
  output logic                                                  mem_en,
  output logic [ADDR_IN_WIDTH-1:0]                              mem_addr,
  input  logic                                                  mem_gnt,
  input  logic [DWIDTH-1:0]                                     mem_rdata
);

  localparam int BAW    = blk_addr_width(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS);
  localparam int B      = words_per_block(BLOCK_WIDTH_BITS);
  localparam int CNT_W  = BLOCK_WIDTH_BITS + 32'd1;
  localparam int LINE_W = DWIDTH * B;

  // Counters are one bit wider than a word index so a full block count fits.
  localparam logic [CNT_W-1:0] B_CNT   = CNT_W'(B);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          issue_q, issue_d;
  logic [CNT_W-1:0]          recv_q, recv_d;
  logic [BAW-1:0]            saddr_q, saddr_d;
  logic                      pend_q, pend_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [LINE_W-1:0]         block_q, block_d;
  logic                      mem_en_q, mem_en_d;
  logic [ADDR_IN_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                      reuse_hit_s;

`ifdef BLOCK_RESP_REUSE_EN
  logic [BAW-1:0] last_q, last_d;
  logic           reuse_vld_q, reuse_vld_d;

  // Track the most recently fetched block and detect a repeat request for it.
  always_comb begin
    last_d      = last_q;
    reuse_vld_d = reuse_vld_q;
    reuse_hit_s = req_valid && reuse_vld_q && (req_addr == last_q);
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      last_d      = saddr_d;
      reuse_vld_d = 1'b1;
    end else begin
      last_d      = last_q;
      reuse_vld_d = reuse_vld_q;
    end
  end

  // Last-served address and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      reuse_vld_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      reuse_vld_q <= reuse_vld_d;
    end
  end
`else
  assign reuse_hit_s = 1'b0;
`endif

  // Next-state, counter, line assembly and memory request computation.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    saddr_d = saddr_q;
    pend_d  = 1'b0;
    line_d  = line_q;
    block_d = block_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          saddr_d = req_addr;
          issue_d = '0;
          recv_d  = '0;
          state_d = reuse_hit_s ? S_RESP : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // A read is only really issued on a granted request cycle.
        pend_d = mem_en_q && mem_gnt;
        if (mem_en_q && mem_gnt) begin
          issue_d = issue_q + CNT_ONE;
        end else begin
          issue_d = issue_q;
        end
        // Data of the previous cycle's issued read lands in the next line slot.
        if (pend_q) begin
          for (int w = 0; w < B; w++) begin
            line_d[w*DWIDTH +: DWIDTH] =
              (recv_q[BLOCK_WIDTH_BITS-1:0] == BLOCK_WIDTH_BITS'(w)) ?
              mem_rdata : line_q[w*DWIDTH +: DWIDTH];
          end
          recv_d = recv_q + CNT_ONE;
        end else begin
          recv_d = recv_q;
        end
        // The completed line (including the word arriving now) becomes visible.
        if (recv_d == B_CNT) begin
          state_d = S_RESP;
          block_d = line_d;
        end else begin
          state_d = S_READ;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Memory request for the cycle after this edge, held in registers.
    mem_en_d = (state_d == S_READ) && (issue_d < B_CNT);
    if (mem_en_d) begin
      mem_addr_d = {saddr_d, issue_d[BLOCK_WIDTH_BITS-1:0]};
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // Control, counter, line and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issue_q    <= '0;
      recv_q     <= '0;
      saddr_q    <= '0;
      pend_q     <= 1'b0;
      line_q     <= '0;
      block_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      saddr_q    <= saddr_d;
      pend_q     <= pend_d;
      line_q     <= line_d;
      block_q    <= block_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Ready follows the live request in the response cycle, so a withdrawn or
  // changed request is not acknowledged.
  assign req_ready  = (state_q == S_RESP) && req_valid && (req_addr == saddr_q);
  assign block_data = block_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;

endmodule
